// File: rtl/noc_rr_arbiter_if.sv
// Request/grant bundle between input-buffer request lines and one output-port arbiter.
interface noc_rr_arbiter_if #(
    parameter int NPORTS = 5,
    parameter int FID_W  = 3,
    parameter int LEN_W  = 12,
    parameter int IDX_W  = $clog2(NPORTS)
);
    logic [NPORTS-1:0]       req;
    logic [NPORTS*FID_W-1:0] flit_id;
    logic [NPORTS*LEN_W-1:0] length;
    logic [NPORTS-1:0]       grant;
    logic                    grant_valid;
    logic [IDX_W-1:0]        grant_idx;
    logic                    timeout_pulse;

    modport master (
        output req, flit_id, length,
        input  grant, grant_valid, grant_idx, timeout_pulse
    );

    modport slave (
        input  req, flit_id, length,
        output grant, grant_valid, grant_idx, timeout_pulse
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter with registered one-hot grant.
// ARB_TIMEOUT_EN enables per-port grant windows latched from header flits.
module noc_rr_arbiter #(
    parameter int               NPORTS    = 5,
    parameter int               FID_W     = 3,
    parameter int               LEN_W     = 12,
    parameter logic [FID_W-1:0] HEADER_ID = FID_W'(1)
) (
    input  logic            clk,
    input  logic            rst,
    noc_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NPORTS);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] last, last_n;
    logic             tp_n;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    // While granting, last always equals the granted port, so one search
    // from last serves both IDLE (last included) and handover (last excluded).
    always_comb begin
        int i;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NPORTS; k++) begin
            i = int'(last) + k;
            if (i >= NPORTS) i = i - NPORTS;
            if (!pick_found && bus.req[i] && (state == IDLE || k != NPORTS)) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [LEN_W-1:0] count, count_n;
    logic [LEN_W-1:0] limit [NPORTS];
    logic [LEN_W-1:0] lim_eff;
    logic             expired;

    for (genvar p = 0; p < NPORTS; p++) begin : g_limit
        always_ff @(posedge clk) begin
            if (rst)
                limit[p] <= '0;
            else if (bus.flit_id[p*FID_W +: FID_W] == HEADER_ID)
                limit[p] <= bus.length[p*LEN_W +: LEN_W];
        end
    end

    // A zero limit still grants for one cycle.
    assign lim_eff = (limit[last] == '0) ? LEN_W'(1) : limit[last];
    assign expired = (count >= lim_eff);
`else
    logic unused_inputs;
    assign unused_inputs = ^{bus.flit_id, bus.length};
`endif

    always_comb begin
        state_n = state;
        last_n  = last;
        tp_n    = 1'b0;
`ifdef ARB_TIMEOUT_EN
        count_n = count;
`endif
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n = GRANT;
                    last_n  = pick_idx;
`ifdef ARB_TIMEOUT_EN
                    count_n = LEN_W'(1);
`endif
                end
            end
            GRANT: begin
                if (!bus.req[last]) begin
                    if (pick_found) last_n = pick_idx;
                    else            state_n = IDLE;
`ifdef ARB_TIMEOUT_EN
                    count_n = pick_found ? LEN_W'(1) : '0;
                end else if (expired) begin
                    // No other requester: the same port gets a fresh window.
                    if (pick_found) last_n = pick_idx;
                    count_n = LEN_W'(1);
                    tp_n    = 1'b1;
                end else begin
                    count_n = count + LEN_W'(1);
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            last              <= IDX_W'(NPORTS - 1);
            bus.grant         <= '0;
            bus.grant_valid   <= 1'b0;
            bus.grant_idx     <= '0;
            bus.timeout_pulse <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            count             <= '0;
`endif
        end else begin
            state             <= state_n;
            last              <= last_n;
            bus.grant         <= (state_n == GRANT) ? (NPORTS'(1) << last_n) : '0;
            bus.grant_valid   <= (state_n == GRANT);
            bus.grant_idx     <= (state_n == GRANT) ? last_n : '0;
            bus.timeout_pulse <= tp_n;
`ifdef ARB_TIMEOUT_EN
            count             <= count_n;
`endif
        end
    end
endmodule

// File: tb/tb_noc_rr_arbiter.sv
// Randomized + directed bench for noc_rr_arbiter against a rule-level reference model.
module tb_noc_rr_arbiter;
    localparam int             NP  = 5;
    localparam int             FW  = 3;
    localparam int             LW  = 12;
    localparam int             IW  = $clog2(NP);
    localparam int             VW  = NP + 1 + IW + 1;
    localparam logic [FW-1:0]  HDR = 3'b001;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    noc_rr_arbiter_if #(.NPORTS(NP), .FID_W(FW), .LEN_W(LW)) bus ();
    noc_rr_arbiter #(.NPORTS(NP), .FID_W(FW), .LEN_W(LW), .HEADER_ID(HDR)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: granted port (-1 idle), cycles spent in window, rotation
    // pointer, latched limits and the pending timeout pulse.
    int m_g    = -1;
    int m_cnt  = 0;
    int m_last = NP - 1;
    int m_tp   = 0;
    int m_lim [NP];

    function automatic int pick(logic [NP-1:0] r, int base, bit incl);
        for (int k = 1; k <= NP; k++) begin
            int i;
            i = (base + k) % NP;
            if ((incl || k != NP) && r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [VW-1:0] expv();
        logic [NP-1:0] g;
        logic [IW-1:0] gi;
        g  = (m_g >= 0) ? (NP'(1) << m_g) : '0;
        gi = (m_g >= 0) ? IW'(m_g) : '0;
        return {g, (m_g >= 0), gi, m_tp[0]};
    endfunction

    function automatic logic [VW-1:0] obs();
        return {bus.grant, bus.grant_valid, bus.grant_idx, bus.timeout_pulse};
    endfunction

    task automatic set_hdr(int p, int len);
        bus.flit_id[p*FW +: FW] = HDR;
        bus.length[p*LW +: LW]  = LW'(len);
    endtask

    task automatic clr_hdr();
        bus.flit_id = '0;
    endtask

    // Advance one clock and apply the arbitration rules to the sampled inputs.
    task automatic step();
        logic [NP-1:0] r;
        int w;
        @(posedge clk);
        r = bus.req;
        if (rst) begin
            m_g = -1; m_cnt = 0; m_last = NP - 1; m_tp = 0;
            for (int i = 0; i < NP; i++) m_lim[i] = 0;
        end else begin
            m_tp = 0;
            if (m_g < 0) begin
                w = pick(r, m_last, 1'b1);
                if (w >= 0) begin m_g = w; m_last = w; m_cnt = 1; end
            end else if (!r[m_g]) begin
                w = pick(r, m_g, 1'b0);
                m_g = w;
                if (w >= 0) begin m_last = w; m_cnt = 1; end
                else m_cnt = 0;
            end else if (TMO && m_cnt >= ((m_lim[m_g] > 0) ? m_lim[m_g] : 1)) begin
                w = pick(r, m_g, 1'b0);
                if (w >= 0) m_g = w;
                m_last = m_g; m_cnt = 1; m_tp = 1;
            end else begin
                m_cnt++;
            end
            for (int i = 0; i < NP; i++)
                if (bus.flit_id[i*FW +: FW] == HDR) m_lim[i] = int'(bus.length[i*LW +: LW]);
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.flit_id = '0; bus.length = '0;
        for (int c = 0; c < 2; c++) begin
            bus.req = NP'($urandom);
            step();
            checks++;
            if (obs() !== {VW{1'b0}}) begin
                errors++; $display("FAIL reset c=%0d got=%h exp=%h", c, obs(), {VW{1'b0}});
            end
        end
        rst = 1'b0; bus.req = 5'b00001;
        step();
        checks++;
        if (bus.grant !== 5'b00001 || obs() !== expv()) begin
            errors++; $display("FAIL reset_first_grant got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_single();
        bus.req = 5'b00100; set_hdr(2, 4);
        for (int c = 0; c < 14; c++) begin
            step();
            if (c == 0) clr_hdr();
            checks++;
            if (obs() !== expv() || bus.grant !== 5'b00100) begin
                errors++; $display("FAIL single c=%0d got=%h exp=%h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_rr_timeout();
        bus.req = 5'b10101;
        for (int p = 0; p < NP; p++) set_hdr(p, 3);
        for (int c = 0; c < 20; c++) begin
            step();
            if (c == 0) clr_hdr();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL rr_timeout c=%0d got=%h exp=%h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_early_release();
        bit got = 1'b0;
        for (int p = 0; p < NP; p++) set_hdr(p, 100);
        bus.req = 5'b00010;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            clr_hdr();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL early_wait c=%0d got=%h exp=%h", c, obs(), expv());
            end
            got = (bus.grant === 5'b00010);
        end
        checks++;
        if (!got) begin
            errors++; $display("FAIL early_timeout got=%h exp=%h", bus.grant, 5'b00010);
        end
        bus.req = 5'b01010;
        step();
        checks++;
        if (obs() !== expv()) begin
            errors++; $display("FAIL early_hold got=%h exp=%h", obs(), expv());
        end
        bus.req = 5'b01000;
        step();
        checks++;
        if (obs() !== expv() || bus.grant !== 5'b01000 || bus.timeout_pulse !== 1'b0) begin
            errors++; $display("FAIL early_release got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_limit0_shrink();
        bus.req = 5'b01000; set_hdr(3, 0);
        for (int c = 0; c < 6; c++) begin
            step();
            clr_hdr();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL limit0 c=%0d got=%h exp=%h", c, obs(), expv());
            end
        end
        bus.req = 5'b00001; set_hdr(0, 10);
        for (int c = 0; c < 10; c++) begin
            step();
            if (c == 3) set_hdr(0, 2);
            else clr_hdr();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL shrink c=%0d got=%h exp=%h", c, obs(), expv());
            end
        end
    endtask

    task automatic test_hold();
        clr_hdr(); bus.req = 5'b00011;
        for (int c = 0; c < 100; c++) begin
            step();
            checks++;
`ifdef ARB_TIMEOUT_EN
            if (obs() !== expv()) begin
`else
            if (obs() !== expv() || bus.grant !== 5'b00001 || bus.timeout_pulse !== 1'b0) begin
`endif
                errors++; $display("FAIL hold c=%0d got=%h exp=%h", c, obs(), expv());
            end
        end
        bus.req = 5'b00010;
        step();
        checks++;
        if (obs() !== expv() || bus.grant !== 5'b00010) begin
            errors++; $display("FAIL hold_drop got=%h exp=%h", obs(), expv());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst     = ($urandom_range(0, 49) == 0);
            bus.req = NP'($urandom);
            for (int p = 0; p < NP; p++) begin
                bus.flit_id[p*FW +: FW] = ($urandom_range(0, 3) == 0) ? HDR : FW'($urandom_range(2, 7));
                bus.length[p*LW +: LW]  = LW'($urandom_range(0, 6));
            end
            step();
            checks++;
            if (obs() !== expv()) begin
                errors++; $display("FAIL random c=%0d got=%h exp=%h", c, obs(), expv());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        bus.req = '0; bus.flit_id = '0; bus.length = '0;
        for (int i = 0; i < NP; i++) m_lim[i] = 0;
        test_reset();
        test_single();
        test_rr_timeout();
        test_early_release();
        test_limit0_shrink();
        test_hold();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
